pio_pattern_sequencer: RTL and testbench

Avalon-MM controller that drives the single-bit output PIO's s1 slave port to play a programmable serial bit pattern (LED blink codes, strobe sequences) without CPU involvement. The CPU configures pattern, bit period and length through a small CSR slave, then starts the sequence. The block issues timed single-cycle writes to PIO address 0. It sits between the Nios/CSR interconnect and the PIO slave and is the only master on that port.

---
 rtl/pio_pattern_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pio_pattern_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_pattern_sequencer.sv
// Plays a programmable serial bit pattern onto a PIO slave through timed single-cycle Avalon-MM writes.
// Latency: first PIO write one cycle after the start write; writes spaced PERIOD cycles apart.
// Backpressure: none; the CSR slave has no waitrequest and the PIO slave accepts every write.
module pio_pattern_sequencer #(
    parameter int CLK_DIV_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  csr_address,
    input  logic        csr_chipselect,
    input  logic        csr_write_n,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy,
    output logic        done_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t               state, state_n;

    // CSR-visible registers
    logic [31:0]          pattern_reg;
    logic [CLK_DIV_W-1:0] period_reg;
    logic [4:0]           length_reg;
    logic                 loop_reg;
    logic                 done_sticky;

    // Copies frozen at start so CSR writes cannot disturb a running sequence
    logic [31:0]          sh_pattern, sh_pattern_n;
    logic [CLK_DIV_W-1:0] sh_period, sh_period_n;
    logic [4:0]           sh_last, sh_last_n;

    logic [4:0]           bit_idx, bit_idx_n;
    logic [CLK_DIV_W-1:0] bit_cnt, bit_cnt_n;

    logic                 done_set;
    logic                 done_clr;
    logic                 pio_wr_n;
    logic [31:0]          pio_dat_n;

    logic                 csr_wr;
    logic                 ctrl_wr;
    logic                 start_req;
    logic                 stop_req;
    logic [CLK_DIV_W-1:0] eff_period;

    assign csr_wr     = csr_chipselect & ~csr_write_n;
    assign ctrl_wr    = csr_wr & (csr_address == 2'd0);
    // Stop wins over start when both arrive in one write
    assign start_req  = ctrl_wr & csr_writedata[0] & ~csr_writedata[2];
    assign stop_req   = ctrl_wr & csr_writedata[2];
    assign eff_period = (period_reg == '0) ? CLK_DIV_W'(1) : period_reg;

    assign pio_address = 2'd0;

    // CSR read mux; unused bits read as zero
    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            2'd0: csr_readdata[2:0] = {done_sticky, loop_reg, busy};
            2'd1: csr_readdata = pattern_reg;
            2'd2: csr_readdata[CLK_DIV_W-1:0] = period_reg;
            2'd3: csr_readdata[4:0] = length_reg;
            default: csr_readdata = '0;
        endcase
    end

    // CSR register writes; the loop bit is live and follows every CONTROL write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_reg <= '0;
            period_reg  <= '0;
            length_reg  <= '0;
            loop_reg    <= 1'b0;
        end else if (csr_wr) begin
            case (csr_address)
                2'd0: loop_reg    <= csr_writedata[1];
                2'd1: pattern_reg <= csr_writedata;
                2'd2: period_reg  <= csr_writedata[CLK_DIV_W-1:0];
                2'd3: length_reg  <= csr_writedata[4:0];
                default: ;
            endcase
        end
    end

    // Next-state, sequencing counters and next PIO bus values
    always_comb begin
        state_n      = state;
        sh_pattern_n = sh_pattern;
        sh_period_n  = sh_period;
        sh_last_n    = sh_last;
        bit_idx_n    = bit_idx;
        bit_cnt_n    = bit_cnt;
        done_set     = 1'b0;
        done_clr     = 1'b0;

        case (state)
            IDLE: begin
                if (start_req) begin
                    state_n      = RUN;
                    sh_pattern_n = pattern_reg;
                    sh_period_n  = eff_period;
                    // LENGTH of 0 wraps to index 31, i.e. a 32-bit pattern
                    sh_last_n    = length_reg - 5'd1;
                    bit_idx_n    = '0;
                    bit_cnt_n    = '0;
                    done_clr     = 1'b1;
                end
            end
            RUN: begin
                if (stop_req) begin
                    state_n = CLEAR;
                end else if (bit_cnt == sh_period - CLK_DIV_W'(1)) begin
                    bit_cnt_n = '0;
                    if (bit_idx == sh_last) begin
                        bit_idx_n = '0;
                        if (!loop_reg) begin
                            state_n  = IDLE;
                            done_set = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 5'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CLK_DIV_W'(1);
                end
            end
            CLEAR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // PIO outputs are registered, so they are derived from next-state values
        pio_wr_n  = ((state_n == RUN) && (bit_cnt_n == '0)) || (state_n == CLEAR);
        pio_dat_n = pio_writedata;
        if (state_n == CLEAR) begin
            pio_dat_n = '0;
        end else if (pio_wr_n) begin
            pio_dat_n = {31'b0, sh_pattern_n[bit_idx_n]};
        end
    end

    // Sequencer state, shadows and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            sh_pattern     <= '0;
            sh_period      <= '0;
            sh_last        <= '0;
            bit_idx        <= '0;
            bit_cnt        <= '0;
            done_sticky    <= 1'b0;
            done_pulse     <= 1'b0;
            busy           <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            state          <= state_n;
            sh_pattern     <= sh_pattern_n;
            sh_period      <= sh_period_n;
            sh_last        <= sh_last_n;
            bit_idx        <= bit_idx_n;
            bit_cnt        <= bit_cnt_n;
            done_pulse     <= done_set;
            busy           <= (state_n != IDLE);
            pio_chipselect <= pio_wr_n;
            pio_write_n    <= ~pio_wr_n;
            pio_writedata  <= pio_dat_n;
            if (done_clr) begin
                done_sticky <= 1'b0;
            end else if (done_set) begin
                done_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Directed bench for pio_pattern_sequencer: vector table plus hand-written multi-cycle sequences.
// Latency: cycle k counts clock periods after the edge that accepted the start write.
// Backpressure: none; CSR writes are issued one per cycle.
module tb_pio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  csr_address = '0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write_n = 1'b1;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;
    logic        done_pulse;

    pio_pattern_sequencer #(.CLK_DIV_W(24)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write_n    (csr_write_n),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .busy           (busy),
        .done_pulse     (done_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Observation record filled by observe()
    int   w_off [64];
    logic w_bit [64];
    int   w_n;
    int   done_k;
    int   done_cnt;
    int   bad_cnt;
    logic busy_at [128];

    // CSR writes scheduled to be driven during observe(), keyed by cycle index
    int          sk [$];
    logic [1:0]  sa [$];
    logic [31:0] sd [$];

    typedef struct {
        logic [31:0] pat;
        logic [31:0] per;
        logic [31:0] len;
        int          n;
        int          gap;
        logic [31:0] bits;
        int          done;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_address    = a;
        csr_writedata  = d;
        csr_chipselect = 1'b1;
        csr_write_n    = 1'b0;
        @(posedge clk);
        #1;
        csr_chipselect = 1'b0;
        csr_write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        #1;
        d = csr_readdata;
    endtask

    task automatic schedule(input int k, input logic [1:0] a, input logic [31:0] d);
        sk.push_back(k);
        sa.push_back(a);
        sd.push_back(d);
    endtask

    // Watch maxk cycles, logging PIO writes, done pulses and busy; drives scheduled CSR writes
    task automatic observe(input int maxk);
        w_n      = 0;
        done_k   = -1;
        done_cnt = 0;
        bad_cnt  = 0;
        for (int k = 1; k <= maxk; k++) begin
            @(negedge clk);
            if (k < 128) busy_at[k] = busy;
            if (pio_address !== 2'd0 || pio_writedata[31:1] !== 31'd0 ||
                pio_chipselect === pio_write_n) bad_cnt++;
            if (pio_chipselect === 1'b1 && pio_write_n === 1'b0 && w_n < 64) begin
                w_off[w_n] = k;
                w_bit[w_n] = pio_writedata[0];
                w_n++;
            end
            if (done_pulse === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            csr_chipselect = 1'b0;
            csr_write_n    = 1'b1;
            if (sk.size() > 0 && sk[0] == k) begin
                csr_address    = sa.pop_front();
                csr_writedata  = sd.pop_front();
                void'(sk.pop_front());
                csr_chipselect = 1'b1;
                csr_write_n    = 1'b0;
            end
        end
        csr_chipselect = 1'b0;
        csr_write_n    = 1'b1;
        check("bus shape", 32'(bad_cnt), 32'd0);
    endtask

    // Writes expected at cycles 1, 1+gap, 1+2*gap ... carrying bits[0], bits[1] ...
    task automatic check_trace(input string nm, input int n, input int gap, input logic [31:0] bits);
        check({nm, " write count"}, 32'(w_n), 32'(n));
        for (int i = 0; i < n && i < w_n; i++) begin
            check($sformatf("%s write %0d cycle", nm, i), 32'(w_off[i]), 32'(1 + i * gap));
            check($sformatf("%s write %0d bit", nm, i), {31'd0, w_bit[i]}, {31'd0, bits[i]});
        end
    endtask

    logic [31:0] rd;

    initial begin
        // pat, per, len, writes, spacing, bits in write order, done cycle
        vecs[0] = '{32'h0000_000B, 32'd3,  32'd4, 4,  3,  32'h0000_000B, 13};
        vecs[1] = '{32'hFFFF_0000, 32'd0,  32'd0, 32, 1,  32'hFFFF_0000, 33};
        vecs[2] = '{32'h0000_005A, 32'd2,  32'd7, 7,  2,  32'h0000_005A, 15};
        vecs[3] = '{32'h1234_5678, 32'd5,  32'd1, 1,  5,  32'h0000_0000, 6};
        vecs[4] = '{32'h8000_0001, 32'd1,  32'd3, 3,  1,  32'h0000_0001, 4};
        vecs[5] = '{32'h0000_0003, 32'd16, 32'd2, 2,  16, 32'h0000_0003, 33};

        // Reset state
        #12;
        check("rst cs", {31'd0, pio_chipselect}, 32'd0);
        check("rst wn", {31'd0, pio_write_n}, 32'd1);
        check("rst wdata", pio_writedata, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done_pulse}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check($sformatf("rst csr%0d", a), rd, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven single-shot sequences
        for (int v = 0; v < 6; v++) begin
            csr_write(2'd1, vecs[v].pat);
            csr_write(2'd2, vecs[v].per);
            csr_write(2'd3, vecs[v].len);
            csr_write(2'd0, 32'h1);
            observe(vecs[v].done + 3);
            check_trace($sformatf("vec%0d", v), vecs[v].n, vecs[v].gap, vecs[v].bits);
            check($sformatf("vec%0d done cycle", v), 32'(done_k), 32'(vecs[v].done));
            check($sformatf("vec%0d done count", v), 32'(done_cnt), 32'd1);
            check($sformatf("vec%0d busy before done", v), {31'd0, busy_at[vecs[v].done - 1]}, 32'd1);
            check($sformatf("vec%0d busy at done", v), {31'd0, busy_at[vecs[v].done]}, 32'd0);
            csr_read(2'd0, rd);
            check($sformatf("vec%0d control", v), rd, 32'h4);
            csr_read(2'd2, rd);
            check($sformatf("vec%0d period readback", v), rd, vecs[v].per);
        end

        // Loop with no gap at wrap, then stop: one zero write, no done
        csr_write(2'd1, 32'h2);
        csr_write(2'd2, 32'd2);
        csr_write(2'd3, 32'd2);
        csr_write(2'd0, 32'h3);
        schedule(8, 2'd0, 32'h4);
        observe(12);
        check_trace("loopstop", 5, 2, 32'h0000_000A);
        check("loopstop done count", 32'(done_cnt), 32'd0);
        check("loopstop busy in clear", {31'd0, busy_at[9]}, 32'd1);
        check("loopstop busy after", {31'd0, busy_at[10]}, 32'd0);
        csr_read(2'd0, rd);
        check("loopstop control", rd, 32'h0);

        // Shadowing: PATTERN write and start while busy do not disturb the run
        csr_write(2'd1, 32'h5);
        csr_write(2'd3, 32'd3);
        csr_write(2'd0, 32'h1);
        schedule(2, 2'd1, 32'h0);
        schedule(3, 2'd0, 32'h1);
        observe(10);
        check_trace("shadow", 3, 2, 32'h5);
        check("shadow done cycle", 32'(done_k), 32'd7);
        check("shadow done count", 32'(done_cnt), 32'd1);
        csr_read(2'd1, rd);
        check("shadow pattern reg", rd, 32'h0);
        csr_write(2'd0, 32'h1);
        observe(10);
        check_trace("shadow rerun", 3, 2, 32'h0);
        check("shadow rerun done cycle", 32'(done_k), 32'd7);

        // Start and stop together while idle: nothing happens
        csr_write(2'd0, 32'h5);
        observe(5);
        check("startstop writes", 32'(w_n), 32'd0);
        check("startstop busy", {31'd0, busy_at[1]}, 32'd0);
        check("startstop done count", 32'(done_cnt), 32'd0);

        // Clearing loop mid-run ends at the next last-bit boundary
        csr_write(2'd1, 32'h2);
        csr_write(2'd3, 32'd2);
        csr_write(2'd0, 32'h3);
        schedule(2, 2'd0, 32'h0);
        observe(9);
        check_trace("loopclr", 2, 2, 32'h2);
        check("loopclr done cycle", 32'(done_k), 32'd5);
        check("loopclr done count", 32'(done_cnt), 32'd1);
        csr_read(2'd0, rd);
        check("loopclr control", rd, 32'h4);

        // Reset mid-run clears everything at once, with no trailing write
        csr_write(2'd1, 32'hF);
        csr_write(2'd2, 32'd4);
        csr_write(2'd3, 32'd4);
        csr_write(2'd0, 32'h3);
        observe(2);
        check("midrst running", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst cs", {31'd0, pio_chipselect}, 32'd0);
        check("midrst wn", {31'd0, pio_write_n}, 32'd1);
        check("midrst wdata", pio_writedata, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done_pulse}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check($sformatf("midrst csr%0d", a), rd, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        observe(6);
        check("postrst writes", 32'(w_n), 32'd0);
        check("postrst busy", {31'd0, busy_at[3]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
